ym3438_timers: RTL and testbench

YM3438_TIMERS -- requirements
Module: ym3438_timers

---
 rtl/ym3438_timers.sv | 172 +++++++++++++++++
 tb/tb_ym3438_timers.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_timers.sv
// YM3438 timer block: timer A, timer B with free-running prescaler,
// overflow flags, interrupt request and CSM key-on pulse.
// Control register 0x27 holds load/enable/mode bits; the reset bits in
// that register act as one-shot flag clears and are never stored.
// No valid/ready handshakes here: tick and reg27_wr are single-cycle
// strobes that are acted on in the cycle they are high.
module ym3438_timers #(
  parameter int TA_WIDTH    = 10,
  parameter int TB_WIDTH    = 8,
  parameter int TB_PRE_BITS = 4
) (
  input  logic                MCLK,
  input  logic                IC,
  input  logic                tick,
  input  logic [TA_WIDTH-1:0] a_value,
  input  logic [TB_WIDTH-1:0] b_value,
  input  logic                reg27_wr,
  input  logic [7:0]          reg27,
  output logic [TA_WIDTH-1:0] cnt_a,
  output logic [TB_WIDTH-1:0] cnt_b,
  output logic                flag_a,
  output logic                flag_b,
  output logic                irq,
  output logic                csm_key
);

  // Latched control bits from register 0x27
  logic       load_a_q;
  logic       load_b_q;
  logic       en_a_q;
  logic       en_b_q;
  logic [1:0] mode_q;

  // Counter and status state
  logic [TA_WIDTH-1:0]    cnt_a_q;
  logic [TB_WIDTH-1:0]    cnt_b_q;
  logic [TB_PRE_BITS-1:0] pre_q;
  logic                   flag_a_q;
  logic                   flag_b_q;
  logic                   irq_q;
  logic                   csm_key_q;

  // Control values as seen by this edge: a write takes effect immediately,
  // so a tick coinciding with the write uses the freshly written bits.
  logic       load_a_eff;
  logic       load_b_eff;
  logic       en_a_eff;
  logic       en_b_eff;
  logic [1:0] mode_eff;

  // Per-edge events
  logic reload_a;
  logic reload_b;
  logic adv_a;
  logic adv_b;
  logic ovf_a;
  logic ovf_b;
  logic pre_wrap;
  logic clr_a;
  logic clr_b;

  // Next-state values
  logic [TA_WIDTH-1:0]    cnt_a_nxt;
  logic [TB_WIDTH-1:0]    cnt_b_nxt;
  logic [TB_PRE_BITS-1:0] pre_nxt;
  logic                   flag_a_nxt;
  logic                   flag_b_nxt;
  logic                   csm_key_nxt;

  // Effective control bits and edge events for the current cycle
  always_comb begin
    load_a_eff = reg27_wr ? reg27[0]   : load_a_q;
    load_b_eff = reg27_wr ? reg27[1]   : load_b_q;
    en_a_eff   = reg27_wr ? reg27[2]   : en_a_q;
    en_b_eff   = reg27_wr ? reg27[3]   : en_b_q;
    mode_eff   = reg27_wr ? reg27[7:6] : mode_q;

    // Only a 0->1 transition of a load bit reloads; rewriting 1 is a no-op.
    reload_a = reg27_wr & reg27[0] & ~load_a_q;
    reload_b = reg27_wr & reg27[1] & ~load_b_q;

    clr_a = reg27_wr & reg27[4];
    clr_b = reg27_wr & reg27[5];

    // Prescaler wraps on the tick that finds it at all-ones.
    pre_wrap = tick & (&pre_q);

    // A reload on the same edge as a tick suppresses the increment.
    adv_a = tick     & load_a_eff & ~reload_a;
    adv_b = pre_wrap & load_b_eff & ~reload_b;

    ovf_a = adv_a & (&cnt_a_q);
    ovf_b = adv_b & (&cnt_b_q);
  end

  // Next-state computation for counters, prescaler, flags and CSM key
  always_comb begin
    cnt_a_nxt = cnt_a_q;
    if (reload_a) begin
      cnt_a_nxt = a_value;
    end else if (adv_a) begin
      cnt_a_nxt = ovf_a ? a_value : cnt_a_q + TA_WIDTH'(1);
    end

    cnt_b_nxt = cnt_b_q;
    if (reload_b) begin
      cnt_b_nxt = b_value;
    end else if (adv_b) begin
      cnt_b_nxt = ovf_b ? b_value : cnt_b_q + TB_WIDTH'(1);
    end

    pre_nxt = tick ? pre_q + TB_PRE_BITS'(1) : pre_q;

    // Set beats clear when both land on the same edge.
    flag_a_nxt = flag_a_q;
    if (ovf_a & en_a_eff) begin
      flag_a_nxt = 1'b1;
    end else if (clr_a) begin
      flag_a_nxt = 1'b0;
    end

    flag_b_nxt = flag_b_q;
    if (ovf_b & en_b_eff) begin
      flag_b_nxt = 1'b1;
    end else if (clr_b) begin
      flag_b_nxt = 1'b0;
    end

    // CSM key-on follows any timer A overflow in CSM mode, enable or not.
    csm_key_nxt = ovf_a & (mode_eff == 2'b10);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge MCLK) begin
    if (!IC) begin
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      en_a_q    <= 1'b0;
      en_b_q    <= 1'b0;
      mode_q    <= 2'b00;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      pre_q     <= '0;
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      irq_q     <= 1'b0;
      csm_key_q <= 1'b0;
    end else begin
      load_a_q  <= load_a_eff;
      load_b_q  <= load_b_eff;
      en_a_q    <= en_a_eff;
      en_b_q    <= en_b_eff;
      mode_q    <= mode_eff;
      cnt_a_q   <= cnt_a_nxt;
      cnt_b_q   <= cnt_b_nxt;
      pre_q     <= pre_nxt;
      flag_a_q  <= flag_a_nxt;
      flag_b_q  <= flag_b_nxt;
      // irq is built from the next flag values so it lines up with the flags.
      irq_q     <= flag_a_nxt | flag_b_nxt;
      csm_key_q <= csm_key_nxt;
    end
  end

  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;
  assign flag_a  = flag_a_q;
  assign flag_b  = flag_b_q;
  assign irq     = irq_q;
  assign csm_key = csm_key_q;

endmodule

// File: tb/tb_ym3438_timers.sv
// Directed testbench for ym3438_timers with hand-computed expectations.
module tb_ym3438_timers;

  localparam int TA_WIDTH    = 10;
  localparam int TB_WIDTH    = 8;
  localparam int TB_PRE_BITS = 4;

  logic                MCLK;
  logic                IC;
  logic                tick;
  logic [TA_WIDTH-1:0] a_value;
  logic [TB_WIDTH-1:0] b_value;
  logic                reg27_wr;
  logic [7:0]          reg27;
  logic [TA_WIDTH-1:0] cnt_a;
  logic [TB_WIDTH-1:0] cnt_b;
  logic                flag_a;
  logic                flag_b;
  logic                irq;
  logic                csm_key;

  int checks;
  int errors;

  ym3438_timers #(
    .TA_WIDTH   (TA_WIDTH),
    .TB_WIDTH   (TB_WIDTH),
    .TB_PRE_BITS(TB_PRE_BITS)
  ) dut (
    .MCLK    (MCLK),
    .IC      (IC),
    .tick    (tick),
    .a_value (a_value),
    .b_value (b_value),
    .reg27_wr(reg27_wr),
    .reg27   (reg27),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .flag_a  (flag_a),
    .flag_b  (flag_b),
    .irq     (irq),
    .csm_key (csm_key)
  );

  // Clock
  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  // One clock edge with the given strobes; outputs are readable on return.
  task automatic do_cycle(input logic t, input logic wr, input logic [7:0] val);
    tick     = t;
    reg27_wr = wr;
    reg27    = val;
    @(posedge MCLK);
    #1;
    tick     = 1'b0;
    reg27_wr = 1'b0;
    reg27    = 8'h00;
  endtask

  task automatic do_reset();
    IC = 1'b0;
    do_cycle(1'b0, 1'b0, 8'h00);
    IC = 1'b1;
  endtask

  // Reset with tick and write also active: reset must win.
  task automatic test_reset();
    IC = 1'b0;
    a_value = 10'd5;
    b_value = 8'd5;
    do_cycle(1'b1, 1'b1, 8'hFF);
    do_cycle(1'b1, 1'b1, 8'hFF);
    checks++; if (cnt_a !== 10'd0) begin errors++; $display("FAIL reset_cnt_a got %0d want 0", cnt_a); end
    checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL reset_cnt_b got %0d want 0", cnt_b); end
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL reset_flag_a got %b want 0", flag_a); end
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL reset_flag_b got %b want 0", flag_b); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (csm_key !== 1'b0) begin errors++; $display("FAIL reset_csm got %b want 0", csm_key); end
    IC = 1'b1;
  endtask

  // Timer A overflow, then flag clear racing with a set.
  task automatic test_timer_a();
    do_reset();
    a_value = 10'd1020;
    do_cycle(1'b0, 1'b1, 8'h05);
    checks++; if (cnt_a !== 10'd1020) begin errors++; $display("FAIL a_load got %0d want 1020", cnt_a); end
    for (int i = 1; i <= 3; i++) do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd1023) begin errors++; $display("FAIL a_tick3_cnt got %0d want 1023", cnt_a); end
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL a_tick3_flag got %b want 0", flag_a); end
    do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd1020) begin errors++; $display("FAIL a_tick4_cnt got %0d want 1020", cnt_a); end
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL a_tick4_flag got %b want 1", flag_a); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL a_tick4_irq got %b want 1", irq); end
    // Bring counter back to all-ones, then clear coincident with overflow.
    for (int i = 1; i <= 3; i++) do_cycle(1'b1, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, 8'h15);
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL set_beats_clr_flag got %b want 1", flag_a); end
    checks++; if (cnt_a !== 10'd1020) begin errors++; $display("FAIL set_beats_clr_cnt got %0d want 1020", cnt_a); end
    do_cycle(1'b0, 1'b1, 8'h15);
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL clr_flag_a got %b want 0", flag_a); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq got %b want 0", irq); end
    checks++; if (cnt_a !== 10'd1020) begin errors++; $display("FAIL rewrite_no_reload got %0d want 1020", cnt_a); end
  endtask

  // Timer B through the 16-tick prescaler.
  task automatic test_timer_b();
    do_reset();
    b_value = 8'd254;
    do_cycle(1'b0, 1'b1, 8'h0A);
    checks++; if (cnt_b !== 8'd254) begin errors++; $display("FAIL b_load got %0d want 254", cnt_b); end
    for (int i = 1; i <= 32; i++) begin
      do_cycle(1'b1, 1'b0, 8'h00);
      if (i == 15) begin
        checks++; if (cnt_b !== 8'd254) begin errors++; $display("FAIL b_tick15 got %0d want 254", cnt_b); end
      end
      if (i == 16) begin
        checks++; if (cnt_b !== 8'd255) begin errors++; $display("FAIL b_tick16 got %0d want 255", cnt_b); end
        checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL b_tick16_flag got %b want 0", flag_b); end
      end
    end
    checks++; if (cnt_b !== 8'd254) begin errors++; $display("FAIL b_tick32 got %0d want 254", cnt_b); end
    checks++; if (flag_b !== 1'b1) begin errors++; $display("FAIL b_tick32_flag got %b want 1", flag_b); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b_tick32_irq got %b want 1", irq); end
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL b_tick32_flag_a got %b want 0", flag_a); end
    // rst_b clears flag_b
    do_cycle(1'b0, 1'b1, 8'h2A);
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL clr_flag_b got %b want 0", flag_b); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_flag_b_irq got %b want 0", irq); end
  endtask

  // CSM mode: every tick overflows an all-ones reload; enable off.
  task automatic test_csm();
    do_reset();
    a_value = 10'd1023;
    do_cycle(1'b0, 1'b1, 8'h81);
    checks++; if (csm_key !== 1'b0) begin errors++; $display("FAIL csm_after_write got %b want 0", csm_key); end
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 1'b0, 8'h00);
      checks++; if (csm_key !== 1'b1) begin errors++; $display("FAIL csm_pulse got %b want 1", csm_key); end
      checks++; if (cnt_a !== 10'd1023) begin errors++; $display("FAIL csm_cnt got %0d want 1023", cnt_a); end
      do_cycle(1'b0, 1'b0, 8'h00);
      checks++; if (csm_key !== 1'b0) begin errors++; $display("FAIL csm_width got %b want 0", csm_key); end
      checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL csm_flag got %b want 0", flag_a); end
    end
  endtask

  // Reset mid-count coinciding with tick, then resume.
  task automatic test_midcount_reset();
    do_reset();
    a_value = 10'd497;
    do_cycle(1'b0, 1'b1, 8'h05);
    for (int i = 1; i <= 3; i++) do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd500) begin errors++; $display("FAIL mid_pre got %0d want 500", cnt_a); end
    IC = 1'b0;
    do_cycle(1'b1, 1'b0, 8'h00);
    IC = 1'b1;
    checks++; if (cnt_a !== 10'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", cnt_a); end
    checks++; if ({flag_a, flag_b, irq, csm_key} !== 4'b0000) begin errors++; $display("FAIL mid_rst_outs got %b want 0000", {flag_a, flag_b, irq, csm_key}); end
    do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd0) begin errors++; $display("FAIL mid_no_count got %0d want 0", cnt_a); end
    do_cycle(1'b0, 1'b1, 8'h01);
    checks++; if (cnt_a !== 10'd497) begin errors++; $display("FAIL mid_reload got %0d want 497", cnt_a); end
    do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd498) begin errors++; $display("FAIL mid_resume got %0d want 498", cnt_a); end
  endtask

  // Load already set: no reload; load cleared: counter freezes.
  task automatic test_freeze();
    do_reset();
    a_value = 10'd700;
    do_cycle(1'b0, 1'b1, 8'h01);
    a_value = 10'd100;
    do_cycle(1'b0, 1'b1, 8'h01);
    checks++; if (cnt_a !== 10'd700) begin errors++; $display("FAIL no_reload got %0d want 700", cnt_a); end
    do_cycle(1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 3; i++) do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd700) begin errors++; $display("FAIL freeze got %0d want 700", cnt_a); end
  endtask

  // Reload versus tick, and new enable applying on the same edge.
  task automatic test_back_to_back();
    do_reset();
    a_value = 10'd300;
    do_cycle(1'b1, 1'b1, 8'h01);
    checks++; if (cnt_a !== 10'd300) begin errors++; $display("FAIL reload_wins got %0d want 300", cnt_a); end
    do_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (cnt_a !== 10'd301) begin errors++; $display("FAIL after_reload got %0d want 301", cnt_a); end
    do_reset();
    a_value = 10'd1023;
    do_cycle(1'b0, 1'b1, 8'h01);
    do_cycle(1'b1, 1'b1, 8'h05);
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL en_first got %b want 1", flag_a); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL en_first_irq got %b want 1", irq); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    IC       = 1'b0;
    tick     = 1'b0;
    reg27_wr = 1'b0;
    reg27    = 8'h00;
    a_value  = '0;
    b_value  = '0;
    test_reset();
    test_timer_a();
    test_timer_b();
    test_csm();
    test_midcount_reset();
    test_freeze();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
